// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, reset PC,
// exception codes and the fetch FSM state encoding.
package if_fetch_stage_pkg;

    localparam int unsigned STALL_BUS    = 4;
    localparam int unsigned EXC_CODE_BUS = 5;

    localparam logic [31:0]             PC_INIT  = 32'hBFC0_0000;
    localparam logic [EXC_CODE_BUS-1:0] EXC_ADEL = 5'h04;
    localparam logic [EXC_CODE_BUS-1:0] EXC_NONE = 5'h10;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrop
    } fetch_state_e;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC and drives an SRAM-like fetch port,
// delivering one word (or an address-error marker) per accepted fetch to IF/ID.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0]             PC_INIT  = if_fetch_stage_pkg::PC_INIT,
    parameter logic [EXC_CODE_BUS-1:0] EXC_ADEL = if_fetch_stage_pkg::EXC_ADEL,
    parameter logic [EXC_CODE_BUS-1:0] EXC_NONE = if_fetch_stage_pkg::EXC_NONE
) (
    input  logic                    cpu_clk_50M,
    input  logic                    cpu_rst_n,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic                    flush,
    input  logic [31:0]             flush_addr,
    input  logic                    jump_flag,
    input  logic [31:0]             jump_addr,
    output logic                    inst_req,
    output logic [31:0]             inst_addr,
    input  logic                    inst_addr_ok,
    input  logic                    inst_data_ok,
    input  logic [31:0]             inst_rdata,
    output logic [31:0]             if_pc,
    output logic [EXC_CODE_BUS-1:0] if_exccode,
    output logic [31:0]             inst_o,
    output logic                    if_valid,
    output logic                    stallreq_if
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  jump_target_q, jump_target_d;
    logic [31:0]  buffer_q, buffer_d;
    logic         jump_pending_q, jump_pending_d;
    logic [31:0]  next_seq_pc;
    logic         done;
    logic         unused_stall;

    assign unused_stall = ^stall[STALL_BUS-1:2];

    // A jump seen in the completing cycle beats one recorded earlier.
    always_comb begin
        next_seq_pc = pc_q + 32'd4;
        if (jump_flag) begin
            next_seq_pc = jump_addr;
        end else if (jump_pending_q) begin
            next_seq_pc = jump_target_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        jump_pending_d = jump_pending_q;
        jump_target_d  = jump_target_q;
        buffer_d       = buffer_q;
        inst_req       = 1'b0;
        stallreq_if    = 1'b0;
        if_valid       = 1'b0;
        inst_o         = 32'd0;
        if_exccode     = EXC_NONE;
        done           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    pc_d    = flush_addr;
                    state_d = misaligned(flush_addr) ? StIdle : StReq;
                end else if (misaligned(pc_q)) begin
                    if_valid   = 1'b1;
                    if_exccode = EXC_ADEL;
                    done       = !stall[1];
                end else if (!stall[0]) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                inst_req    = 1'b1;
                stallreq_if = 1'b1;
                if (flush) begin
                    pc_d = flush_addr;
                    // An accepted request must still have its response swallowed.
                    if (inst_addr_ok) begin
                        state_d = StDrop;
                    end else if (misaligned(flush_addr)) begin
                        state_d = StIdle;
                    end
                end else if (inst_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                stallreq_if = 1'b1;
                if (flush) begin
                    pc_d    = flush_addr;
                    state_d = inst_data_ok ? StIdle : StDrop;
                end else if (inst_data_ok) begin
                    if (!stall[1]) begin
                        if_valid = 1'b1;
                        inst_o   = inst_rdata;
                        done     = 1'b1;
                    end else begin
                        buffer_d = inst_rdata;
                        state_d  = StHold;
                    end
                end
            end
            StHold: begin
                if (flush) begin
                    pc_d    = flush_addr;
                    state_d = StIdle;
                end else if (!stall[1]) begin
                    if_valid = 1'b1;
                    inst_o   = buffer_q;
                    done     = 1'b1;
                end
            end
            StDrop: begin
                if (flush) begin
                    pc_d = flush_addr;
                end
                if (inst_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            pc_d           = next_seq_pc;
            jump_pending_d = 1'b0;
            state_d        = StIdle;
        end else if (flush) begin
            jump_pending_d = 1'b0;
        end else if (jump_flag) begin
            jump_pending_d = 1'b1;
            jump_target_d  = jump_addr;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q        <= StIdle;
            pc_q           <= PC_INIT;
            jump_pending_q <= 1'b0;
            jump_target_q  <= 32'd0;
            buffer_q       <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            jump_pending_q <= jump_pending_d;
            jump_target_q  <= jump_target_d;
            buffer_q       <= buffer_d;
        end
    end

    assign inst_addr = pc_q;
    assign if_pc     = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed fetch/hold/flush/jump/reset
// scenarios plus randomized memory latencies and jumps against an address-sequence model.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [STALL_BUS-1:0]    stall;
    logic                    flush;
    logic [31:0]             flush_addr;
    logic                    jump_flag;
    logic [31:0]             jump_addr;
    logic                    inst_req;
    logic [31:0]             inst_addr;
    logic                    inst_addr_ok;
    logic                    inst_data_ok;
    logic [31:0]             inst_rdata;
    logic [31:0]             if_pc;
    logic [EXC_CODE_BUS-1:0] if_exccode;
    logic [31:0]             inst_o;
    logic                    if_valid;
    logic                    stallreq_if;

    int passed = 0;
    int total  = 0;

    if_fetch_stage dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .stall       (stall),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .if_pc       (if_pc),
        .if_exccode  (if_exccode),
        .inst_o      (inst_o),
        .if_valid    (if_valid),
        .stallreq_if (stallreq_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, inst_req},    32'd0);
        chk({tag, "_valid"}, {31'd0, if_valid},    32'd0);
        chk({tag, "_insto"}, inst_o,               32'd0);
        chk({tag, "_pc"},    if_pc,                32'hBFC0_0000);
        chk({tag, "_exc"},   {27'd0, if_exccode},  32'h10);
        chk({tag, "_sreq"},  {31'd0, stallreq_if}, 32'd0);
    endtask

    // Wait (bounded) for a request, check its address, accept it after alat cycles.
    task automatic issue(input int alat, input logic [31:0] ea);
        int n;
        n = 0;
        #1;
        while (inst_req !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("req_seen", {31'd0, inst_req}, 32'd1);
        chk("req_addr", inst_addr, ea);
        for (int i = 0; i < alat; i++) begin
            tick();
            #1;
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        #1;
        chk("req_dropped", {31'd0, inst_req}, 32'd0);
        chk("wait_stallreq", {31'd0, stallreq_if}, 32'd1);
    endtask

    // Return the word after dlat cycles, optionally raising a jump while outstanding.
    task automatic complete(input int dlat, input bit jmp, input logic [31:0] jt,
                            input logic [31:0] ea);
        logic [31:0] w;
        w = $urandom;
        for (int i = 0; i < dlat; i++) begin
            if (jmp && i == 0) begin
                jump_flag = 1'b1;
                jump_addr = jt;
            end
            #1;
            chk("wait_no_valid", {31'd0, if_valid}, 32'd0);
            tick();
            jump_flag = 1'b0;
        end
        if (jmp && dlat == 0) begin
            jump_flag = 1'b1;
            jump_addr = jt;
        end
        inst_data_ok = 1'b1;
        inst_rdata   = w;
        #1;
        chk("deliver_valid", {31'd0, if_valid}, 32'd1);
        chk("deliver_inst", inst_o, w);
        chk("deliver_pc", if_pc, ea);
        chk("deliver_exc", {27'd0, if_exccode}, 32'h10);
        tick();
        inst_data_ok = 1'b0;
        jump_flag    = 1'b0;
    endtask

    task automatic fetch_one(input int alat, input int dlat, input bit jmp,
                             input logic [31:0] jt, input logic [31:0] ea);
        issue(alat, ea);
        complete(dlat, jmp, jt, ea);
    endtask

    initial begin
        logic [31:0] ea;
        logic [31:0] jt;
        logic [31:0] w;
        bit          jmp;

        rst_n        = 1'b0;
        stall        = '0;
        flush        = 1'b0;
        flush_addr   = 32'd0;
        jump_flag    = 1'b0;
        jump_addr    = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        tick();
        tick();
        #1;
        chk_reset_outputs("reset");

        // First request appears in the second cycle after release.
        rst_n = 1'b1;
        #1;
        chk("rel_cycle1_req", {31'd0, inst_req}, 32'd0);
        tick();
        #1;
        chk("rel_cycle2_req", {31'd0, inst_req}, 32'd1);
        chk("rel_cycle2_addr", inst_addr, 32'hBFC0_0000);

        fetch_one(1, 1, 1'b0, 32'd0, 32'hBFC0_0000);
        fetch_one(1, 1, 1'b0, 32'd0, 32'hBFC0_0004);

        // Response arrives under IF/ID stall: buffered, delivered when stall drops.
        issue(1, 32'hBFC0_0008);
        w            = $urandom;
        stall        = 4'b0011;
        inst_data_ok = 1'b1;
        inst_rdata   = w;
        #1;
        chk("hold_entry_valid", {31'd0, if_valid}, 32'd0);
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_valid", {31'd0, if_valid}, 32'd0);
            chk("hold_no_req", {31'd0, inst_req}, 32'd0);
            chk("hold_insto", inst_o, 32'd0);
            chk("hold_sreq", {31'd0, stallreq_if}, 32'd0);
            tick();
        end
        stall = '0;
        #1;
        chk("hold_release_valid", {31'd0, if_valid}, 32'd1);
        chk("hold_release_inst", inst_o, w);
        chk("hold_release_pc", if_pc, 32'hBFC0_0008);
        tick();
        #1;
        chk("hold_one_pulse", {31'd0, if_valid}, 32'd0);
        fetch_one(1, 1, 1'b0, 32'd0, 32'hBFC0_000C);

        // Jump while BFC00010 is outstanding: delay slot delivered, then target.
        fetch_one(1, 2, 1'b1, 32'h8000_0100, 32'hBFC0_0010);
        fetch_one(0, 1, 1'b0, 32'd0, 32'h8000_0100);
        fetch_one(1, 0, 1'b0, 32'd0, 32'h8000_0104);

        // Flush in WAIT: stale response dropped, refetch at handler.
        issue(1, 32'h8000_0108);
        flush      = 1'b1;
        flush_addr = 32'hBFC0_0380;
        #1;
        chk("flush_wait_valid", {31'd0, if_valid}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("drop_sreq", {31'd0, stallreq_if}, 32'd0);
        chk("drop_req", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = $urandom;
        #1;
        chk("drop_valid", {31'd0, if_valid}, 32'd0);
        chk("drop_insto", inst_o, 32'd0);
        tick();
        inst_data_ok = 1'b0;
        fetch_one(1, 1, 1'b0, 32'd0, 32'hBFC0_0380);

        // Flush to a misaligned handler: address error reported, no request.
        issue(1, 32'hBFC0_0384);
        flush      = 1'b1;
        flush_addr = 32'hBFC0_0381;
        tick();
        flush        = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = $urandom;
        tick();
        inst_data_ok = 1'b0;
        #1;
        chk("adel_no_req", {31'd0, inst_req}, 32'd0);
        chk("adel_valid", {31'd0, if_valid}, 32'd1);
        chk("adel_exc", {27'd0, if_exccode}, 32'h04);
        chk("adel_pc", if_pc, 32'hBFC0_0381);
        chk("adel_insto", inst_o, 32'd0);
        tick();
        flush      = 1'b1;
        flush_addr = 32'hBFC0_0400;
        tick();
        flush = 1'b0;
        fetch_one(1, 1, 1'b0, 32'd0, 32'hBFC0_0400);

        // PC wrap past the top of the address space.
        fetch_one(0, 1, 1'b1, 32'hFFFF_FFFC, 32'hBFC0_0404);
        fetch_one(1, 0, 1'b0, 32'd0, 32'hFFFF_FFFC);
        ea = 32'h0000_0000;

        // Random latencies and jumps; model: next address is target if jumped, else +4.
        for (int k = 0; k < 30; k++) begin
            jmp = ($urandom_range(0, 3) == 0);
            jt  = $urandom & 32'hFFFF_FFFC;
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), jmp, jt, ea);
            ea = jmp ? jt : ea + 32'd4;
        end

        // Asynchronous reset in the middle of WAIT.
        issue(2, ea);
        inst_data_ok = 1'b1;
        inst_rdata   = $urandom;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        inst_data_ok = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        fetch_one(1, 1, 1'b0, 32'd0, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have ports: cpu_clk_50M  in  1  sole clock, all state updates on its rising edge.
REQ-002 SHALL have ports: cpu_rst_n  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have ports: stall  in  STALL_BUS (4)  stall[0]=hold PC, stall[1]=hold IF/ID; a value of 1 means stop.
REQ-004 SHALL have ports: flush  in  1  exception flush; flush_addr  in  32  handler entry PC.
REQ-005 SHALL have ports: jump_flag  in  1  taken branch/jump from ID; jump_addr  in  32  target.
REQ-006 SHALL have ports: inst_req  out  1, inst_addr  out  32, inst_addr_ok  in  1, inst_data_ok  in  1, inst_rdata  in  32; these form the SRAM-like fetch port.
REQ-007 SHALL have ports: if_pc  out  32, if_exccode  out  EXC_CODE_BUS (5), inst_o  out  32, if_valid  out  1; all four feed the IF/ID register.
REQ-008 SHALL have ports: stallreq_if  out  1  requests a pipeline stall while a fetch is outstanding.
REQ-009 SHALL use these parameters: PC_INIT, default 32'hBFC00000, reset PC; EXC_ADEL, default 5'h04, fetch address error code; EXC_NONE, default 5'h10, no exception.

Function
REQ-010 SHALL hold the fetch PC in register pc, with next-PC priority: flush -> flush_addr; then pending/current jump -> jump_addr; then pc+4; pc SHALL hold while stall[0]=1 or a fetch is incomplete.
REQ-011 SHALL run FSM states IDLE, REQ, WAIT, HOLD, DROP.
REQ-012 IDLE: if pc[1:0]!=0, SHALL NOT issue a request; it SHALL present if_exccode=EXC_ADEL, inst_o=0, if_valid=1 for one accepted cycle, then advance; otherwise it SHALL go to REQ.
REQ-013 REQ: SHALL assert inst_req=1 with inst_addr=pc; on inst_addr_ok=1 it SHALL go to WAIT; inst_req SHALL drop the cycle after addr_ok.
REQ-014 WAIT: on inst_data_ok=1, if stall[1]=0 it SHALL present inst_rdata as inst_o with if_valid=1, update pc, and go to IDLE; if stall[1]=1 it SHALL latch inst_rdata into buffer and go to HOLD.
REQ-015 HOLD: SHALL present the buffered word; when stall[1]=0 it SHALL assert if_valid=1 for one cycle, update pc, and go to IDLE.
REQ-016 flush in REQ-after-addr_ok, WAIT or HOLD: SHALL load pc=flush_addr; from WAIT it SHALL go to DROP, from HOLD to IDLE; if_valid SHALL be 0 that cycle.
REQ-017 DROP: SHALL discard the next inst_data_ok response without asserting if_valid, then go to IDLE; a flush in DROP SHALL only update pc.
REQ-018 flush in IDLE, or in REQ before addr_ok: SHALL load pc=flush_addr and keep or return to REQ with the new address.
REQ-019 jump_flag while a fetch is outstanding: SHALL record jump_pending=1 and jump_target; at completion it SHALL set pc=jump_target, not pc+4; the in-flight word (the delay slot) SHALL still be delivered.
REQ-020 flush SHALL clear jump_pending; when flush and jump_flag occur in the same cycle, flush SHALL win.
REQ-021 stallreq_if SHALL be 1 in REQ and WAIT, and 0 in IDLE, HOLD and DROP.
REQ-022 if_pc SHALL equal the address of the word presented; if_exccode SHALL be EXC_NONE for successful fetches; pc+4 SHALL wrap modulo 2^32.
REQ-023 When if_valid=0, inst_o SHALL be 0.

Reset
REQ-024 On cpu_rst_n=0, asynchronously: pc=PC_INIT, state=IDLE, inst_req=0, if_valid=0, inst_o=0, if_pc=PC_INIT, if_exccode=EXC_NONE, jump_pending=0, buffer=0, stallreq_if=0.
REQ-025 Reset during WAIT SHALL abandon the transaction; the fetch port owner is reset by the same signal.
REQ-026 The first request SHALL be issued in the second cycle after reset release.

Structure
REQ-027 PC_INIT, EXC_NONE, EXC_ADEL, STALL_BUS, EXC_CODE_BUS and the FSM state encoding SHALL live in the shared defines package.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 Reset release with addr_ok and data_ok each returned after 1 cycle -> inst_addr=BFC00000, then BFC00004; inst_o matches rdata, and if_valid is pulsed once per word.
REQ-030 data_ok arrives while stall[1]=1 for 3 cycles -> word buffered in HOLD; if_valid rises on the cycle stall[1] falls; no second request is issued meanwhile.
REQ-031 flush (flush_addr=BFC00380) while in WAIT -> next data_ok dropped with if_valid=0; next request uses addr BFC00380.
REQ-032 jump_flag with target 8000_0100 during WAIT at pc=BFC00010 -> BFC00010 delivered, next request 8000_0100, not BFC00014.
REQ-033 flush_addr=BFC00381 -> no inst_req; if_exccode=04, if_pc=BFC00381, if_valid=1.
REQ-034 Async reset asserted mid-WAIT -> all outputs at reset values immediately, without waiting for a clock edge.
